// File: rtl/l2_mem_scheduler.sv
// l2_mem_scheduler: round-robin sharing of one memory port among L2 banks, with in-order
// response routing through a bank-ID tracking FIFO.
module l2_mem_scheduler #(
    parameter int NUM_BANKS   = 2,
    parameter int OUTST_DEPTH = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_BANKS-1:0]           bank_req_valid,
    input  logic [NUM_BANKS-1:0]           bank_req_we,
    input  logic [NUM_BANKS*AW-1:0]        bank_req_addr,
    input  logic [NUM_BANKS*DW-1:0]        bank_req_wdata,
    output logic [NUM_BANKS-1:0]           bank_res_ready,
    output logic [NUM_BANKS-1:0]           bank_res_valid,
    output logic [NUM_BANKS*DW-1:0]        bank_res_data,
    output logic                           mem_req_valid,
    output logic                           mem_req_we,
    output logic [AW-1:0]                  mem_req_addr,
    output logic [DW-1:0]                  mem_req_wdata,
    input  logic                           mem_res_ready,
    input  logic                           mem_res_valid,
    input  logic [DW-1:0]                  mem_res_data,
    output logic                           busy,
    output logic [$clog2(OUTST_DEPTH):0]   outst,
    output logic                           timeout,
    output logic                           err
);
    localparam int IW = $clog2(NUM_BANKS);
    localparam int PW = $clog2(OUTST_DEPTH);
    localparam int OW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [OW-1:0] FULL = OW'(OUTST_DEPTH);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr, win, head;
    logic [IW-1:0] ids [OUTST_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          any, capture, pop;

    // Lowest valid bank overall, overridden by the lowest valid bank at or above rr_ptr.
    always_comb begin
        win = rr_ptr;
        any = 1'b0;
        for (int b = NUM_BANKS - 1; b >= 0; b--)
            if (bank_req_valid[b]) begin
                win = IW'(b);
                any = 1'b1;
            end
        for (int b = NUM_BANKS - 1; b >= 0; b--)
            if (bank_req_valid[b] && IW'(b) >= rr_ptr) win = IW'(b);
    end

    assign head     = ids[rd_ptr];
    assign capture  = !rst && state == IDLE && any && !flush && outst != FULL;
    assign pop      = mem_res_valid && outst != '0;
    assign tcnt_nxt = (pop || outst == '0) ? '0 : (tcnt == TMAX ? tcnt : tcnt + 1'b1);
    assign busy     = state != IDLE || outst != '0;
    assign bank_res_ready = capture ? {{(NUM_BANKS-1){1'b0}}, 1'b1} << win : '0;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_res
        assign bank_res_valid[b]          = pop && head == IW'(b);
        assign bank_res_data[b*DW +: DW]  = bank_res_valid[b] ? mem_res_data : '0;
    end

    always_ff @(posedge clk)
        if (capture) ids[wr_ptr] <= win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outst         <= '0;
            tcnt          <= '0;
            timeout       <= 1'b0;
            err           <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else begin
            outst <= outst + OW'(capture) - OW'(pop);
            tcnt  <= tcnt_nxt;
            if (tcnt_nxt == TMAX) timeout <= 1'b1;
            if (mem_res_valid && outst == '0) err <= 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (capture) begin
                state         <= ISSUE;
                wr_ptr        <= wr_ptr + 1'b1;
                rr_ptr        <= win == IW'(NUM_BANKS - 1) ? '0 : win + 1'b1;
                mem_req_valid <= 1'b1;
                mem_req_we    <= bank_req_we[win];
                mem_req_addr  <= bank_req_addr[win*AW +: AW];
                mem_req_wdata <= bank_req_wdata[win*DW +: DW];
            end else if (state == ISSUE && mem_res_ready) begin
                state         <= IDLE;
                mem_req_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_l2_mem_scheduler.sv
// tb_l2_mem_scheduler: directed scenario tests for l2_mem_scheduler with hand-computed expectations.
module tb_l2_mem_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush;
    logic [1:0]  bank_req_valid, bank_req_we;
    logic [63:0] bank_req_addr, bank_req_wdata;
    logic [1:0]  bank_res_ready, bank_res_valid;
    logic [63:0] bank_res_data;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_res_ready, mem_res_valid;
    logic [31:0] mem_res_data;
    logic        busy, timeout, err;
    logic [2:0]  outst;
    int checks = 0;
    int failures = 0;

    l2_mem_scheduler #(.NUM_BANKS(2), .OUTST_DEPTH(4), .TIMEOUT_CYC(16), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .bank_req_valid(bank_req_valid), .bank_req_we(bank_req_we),
        .bank_req_addr(bank_req_addr), .bank_req_wdata(bank_req_wdata),
        .bank_res_ready(bank_res_ready), .bank_res_valid(bank_res_valid), .bank_res_data(bank_res_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_res_ready(mem_res_ready), .mem_res_valid(mem_res_valid), .mem_res_data(mem_res_data),
        .busy(busy), .outst(outst), .timeout(timeout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        flush = 0; bank_req_valid = 0; bank_req_we = 0; bank_req_addr = 0; bank_req_wdata = 0;
        mem_res_ready = 0; mem_res_valid = 0; mem_res_data = 0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        bank_req_valid = 2'b11; mem_res_valid = 1; mem_res_ready = 1;
        rst = 1;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%h exp=0", mem_req_addr); end
        checks++; if (outst !== 3'd0) begin failures++; $display("FAIL reset_outst got=%0d exp=0", outst); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({timeout, err} !== 2'b00) begin failures++; $display("FAIL reset_sticky got=%b exp=00", {timeout, err}); end
        checks++; if (bank_res_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", bank_res_ready); end
        checks++; if (bank_res_valid !== 2'b00) begin failures++; $display("FAIL reset_res_valid got=%b exp=00", bank_res_valid); end
        step();
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_single;
        apply_reset();
        bank_req_valid = 2'b01; bank_req_addr = {32'h0, 32'h100}; mem_res_ready = 1;
        #1;
        checks++; if (bank_res_ready !== 2'b01) begin failures++; $display("FAIL single_strobe got=%b exp=01", bank_res_ready); end
        step();
        bank_req_valid = 0;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin failures++; $display("FAIL single_issue got=%b/%h exp=1/100", mem_req_valid, mem_req_addr); end
        checks++; if (outst !== 3'd1) begin failures++; $display("FAIL single_outst got=%0d exp=1", outst); end
        checks++; if (bank_res_ready !== 2'b00) begin failures++; $display("FAIL single_no_strobe got=%b exp=00", bank_res_ready); end
        step();
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL single_req_drop got=%b exp=0", mem_req_valid); end
        step(); step(); step();
        mem_res_valid = 1; mem_res_data = 32'hCAFE;
        #1;
        checks++; if (bank_res_valid !== 2'b01) begin failures++; $display("FAIL single_res_valid got=%b exp=01", bank_res_valid); end
        checks++; if (bank_res_data !== {32'h0, 32'hCAFE}) begin failures++; $display("FAIL single_res_data got=%h exp=%h", bank_res_data, {32'h0, 32'hCAFE}); end
        step();
        mem_res_valid = 0;
        #1;
        checks++; if (outst !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL single_done got=%0d/%b exp=0/0", outst, busy); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        apply_reset();
        bank_req_valid = 2'b11; bank_req_addr = {32'h300, 32'h200}; mem_res_ready = 1;
        for (int k = 0; k <= 8; k++) begin
            #1;
            exp = (k % 2 == 1 || k == 8) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10);
            checks++; if (bank_res_ready !== exp) begin failures++; $display("FAIL rr_strobe c%0d got=%b exp=%b", k, bank_res_ready, exp); end
            if (k % 2 == 1) begin
                checks++; if (mem_req_addr !== ((k % 4 == 1) ? 32'h200 : 32'h300)) begin failures++; $display("FAIL rr_addr c%0d got=%h", k, mem_req_addr); end
            end
            step();
        end
        bank_req_valid = 0;
        checks++; if (outst !== 3'd4) begin failures++; $display("FAIL rr_full got=%0d exp=4", outst); end
        for (int i = 0; i < 4; i++) begin
            mem_res_valid = 1; mem_res_data = 32'h10 + i;
            #1;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (bank_res_valid !== exp) begin failures++; $display("FAIL rr_route r%0d got=%b exp=%b", i, bank_res_valid, exp); end
            checks++; if (bank_res_data[(i % 2) * 32 +: 32] !== 32'h10 + i) begin failures++; $display("FAIL rr_data r%0d got=%h exp=%h", i, bank_res_data[(i % 2) * 32 +: 32], 32'h10 + i); end
            step();
        end
        mem_res_valid = 0;
        checks++; if (outst !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL rr_drain got=%0d/%b exp=0/0", outst, err); end
    endtask

    task automatic test_stall;
        apply_reset();
        bank_req_valid = 2'b01; bank_req_we = 2'b01; bank_req_addr = {32'h500, 32'h400};
        bank_req_wdata = {32'h66, 32'h55};
        #1;
        checks++; if (bank_res_ready !== 2'b01) begin failures++; $display("FAIL stall_strobe got=%b exp=01", bank_res_ready); end
        step();
        bank_req_valid = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            #1;
            checks++; if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b1, 32'h400, 32'h55}) begin failures++; $display("FAIL stall_hold c%0d got=%b/%b/%h/%h", k, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata); end
            checks++; if (bank_res_ready !== 2'b00) begin failures++; $display("FAIL stall_strobe c%0d got=%b exp=00", k, bank_res_ready); end
            step();
        end
        mem_res_ready = 1;
        step();
        mem_res_ready = 0;
        #1;
        checks++; if (mem_req_valid !== 1'b0 || bank_res_ready !== 2'b10) begin failures++; $display("FAIL stall_release got=%b/%b exp=0/10", mem_req_valid, bank_res_ready); end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        bank_req_valid = 2'b11; mem_res_ready = 1;
        repeat (8) step();
        mem_res_valid = 1;
        #1;
        checks++; if (bank_res_ready !== 2'b00 || outst !== 3'd4) begin failures++; $display("FAIL b2b_blocked got=%b/%0d exp=00/4", bank_res_ready, outst); end
        checks++; if (bank_res_valid !== 2'b01) begin failures++; $display("FAIL b2b_r0 got=%b exp=01", bank_res_valid); end
        step();
        #1;
        checks++; if (bank_res_ready !== 2'b01 || bank_res_valid !== 2'b10) begin failures++; $display("FAIL b2b_push_pop got=%b/%b exp=01/10", bank_res_ready, bank_res_valid); end
        step();
        bank_req_valid = 0;
        #1;
        checks++; if (outst !== 3'd3) begin failures++; $display("FAIL b2b_outst got=%0d exp=3", outst); end
        checks++; if (bank_res_valid !== 2'b01) begin failures++; $display("FAIL b2b_r2 got=%b exp=01", bank_res_valid); end
        step();
        checks++; if (bank_res_valid !== 2'b10) begin failures++; $display("FAIL b2b_r3 got=%b exp=10", bank_res_valid); end
        step();
        checks++; if (bank_res_valid !== 2'b01) begin failures++; $display("FAIL b2b_r4 got=%b exp=01", bank_res_valid); end
        step();
        mem_res_valid = 0;
        #1;
        checks++; if (outst !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0d/%b exp=0/0", outst, err); end
    endtask

    task automatic test_timeout;
        apply_reset();
        bank_req_valid = 2'b01; mem_res_ready = 1;
        step();
        bank_req_valid = 0;
        repeat (15) step();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", timeout); end
        step();
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_set got=%b exp=1", timeout); end
        mem_res_valid = 1;
        step();
        #1;
        checks++; if (bank_res_valid !== 2'b00) begin failures++; $display("FAIL stray_routed got=%b exp=00", bank_res_valid); end
        step();
        mem_res_valid = 0;
        #1;
        checks++; if (err !== 1'b1 || timeout !== 1'b1) begin failures++; $display("FAIL stray_err got=%b/%b exp=1/1", err, timeout); end
    endtask

    task automatic test_flush_reset;
        apply_reset();
        bank_req_valid = 2'b01; mem_res_ready = 1;
        step();
        flush = 1; bank_req_valid = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            mem_res_valid = (k == 4);
            #1;
            checks++; if (bank_res_ready !== 2'b00) begin failures++; $display("FAIL flush_strobe c%0d got=%b exp=00", k, bank_res_ready); end
            if (k == 4) begin
                checks++; if (bank_res_valid !== 2'b01) begin failures++; $display("FAIL flush_res got=%b exp=01", bank_res_valid); end
            end
            step();
        end
        mem_res_valid = 0; flush = 0;
        #1;
        checks++; if (bank_res_ready !== 2'b10) begin failures++; $display("FAIL flush_release got=%b exp=10", bank_res_ready); end
        step();
        mem_res_ready = 0;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || outst !== 3'd1) begin failures++; $display("FAIL pre_reset got=%b/%0d exp=1/1", mem_req_valid, outst); end
        rst = 1;
        #1;
        checks++; if ({mem_req_valid, busy, bank_res_ready, outst} !== 7'b0) begin failures++; $display("FAIL async_reset got=%b/%b/%b/%0d exp=0", mem_req_valid, busy, bank_res_ready, outst); end
        step();
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
